// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT valid/ready demultiplexer with one output register per lane,
// broadcast mode and out-of-range select drop accounting.
module stream_demux #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         din,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     bcast,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] dout,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic                     err,
  output logic [7:0]               drop_cnt
);

  logic [NUM_OUT-1:0]       valid_r;
  logic [NUM_OUT*WIDTH-1:0] data_r;
  logic                     err_r;
  logic [7:0]               drop_cnt_r;

  logic [NUM_OUT-1:0]       can_wr_s;
  logic [NUM_OUT-1:0]       hit_s;
  logic [NUM_OUT-1:0]       wr_s;
  logic                     sel_ok_s;
  logic                     in_ready_s;
  logic                     accept_s;
  logic                     drop_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // A full lane that is being drained this cycle can be refilled on the same edge.
  assign can_wr_s = ~valid_r | out_ready;

  // One-hot decode of the unicast target; all-zero means sel is out of range.
  always_comb begin
    hit_s = {NUM_OUT{1'b0}};
    for (int k = 0; k < NUM_OUT; k++) begin
      if (sel == SEL_W'(k)) begin
        hit_s[k] = 1'b1;
      end else begin
        hit_s[k] = 1'b0;
      end
    end
  end

  // Handshake decision and per-lane write enables.
  always_comb begin
    sel_ok_s   = |hit_s;
    in_ready_s = 1'b1;
    wr_s       = {NUM_OUT{1'b0}};
    drop_s     = 1'b0;
    if (bcast) begin
      in_ready_s = &can_wr_s;
    end else if (sel_ok_s) begin
      in_ready_s = |(hit_s & can_wr_s);
    end else begin
      in_ready_s = 1'b1;
    end
    accept_s = in_valid & in_ready_s;
    if (!accept_s) begin
      wr_s   = {NUM_OUT{1'b0}};
      drop_s = 1'b0;
    end else if (bcast) begin
      wr_s = {NUM_OUT{1'b1}};
    end else if (sel_ok_s) begin
      wr_s = hit_s;
    end else begin
      drop_s = 1'b1;
    end
  end

  // Lane registers; data is cleared on drain so an empty lane always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {NUM_OUT{1'b0}};
      data_r  <= {(NUM_OUT*WIDTH){1'b0}};
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (wr_s[k]) begin
          valid_r[k]                <= 1'b1;
          data_r[k*WIDTH +: WIDTH]  <= din;
        end else if (valid_r[k] && out_ready[k]) begin
          valid_r[k]                <= 1'b0;
          data_r[k*WIDTH +: WIDTH]  <= {WIDTH{1'b0}};
        end else begin
          valid_r[k]                <= valid_r[k];
          data_r[k*WIDTH +: WIDTH]  <= data_r[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r      <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      err_r <= drop_s;
      if (drop_s) begin
        drop_cnt_r <= sat_inc(drop_cnt_r);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign dout      = data_r;
  assign out_valid = valid_r;
  assign err       = err_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-NUM_OUT demultiplexer with valid/ready flow control, a broadcast mode and out-of-range select detection. It is the parametrised successor of the two-way combinational demux and steers a WIDTH-bit input word to one of NUM_OUT output lanes. Each lane has its own one-entry output register, so a stalled lane never corrupts data bound for another lane. It sits between a single producer and several independent consumers in the lab datapath.

## Interface

Parameters:
- WIDTH, 8: data width per word.
- NUM_OUT, 4: number of output lanes, from 2 to 16.
- SEL_W, 2: select width. Must satisfy 2**SEL_W >= NUM_OUT.

Ports:
- clk  input  1  single clock. All state changes on the rising edge.
- rst_n  input  1  reset. Asynchronous assert, active-low.
- din  input  WIDTH  input data word.
- sel  input  SEL_W  destination lane index. Ignored when bcast=1.
- bcast  input  1  broadcast mode: the word goes to every lane.
- in_valid  input  1  producer has a word on din/sel/bcast.
- in_ready  output  1  block can accept the word this cycle. Combinational.
- dout  output  NUM_OUT*WIDTH  lane data. Lane k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  NUM_OUT  lane k holds a word.
- out_ready  input  NUM_OUT  consumer k takes the word this cycle.
- err  output  1  one-cycle pulse when a word with out-of-range sel is accepted and dropped.
- drop_cnt  output  8  count of dropped words. Saturates at 255.

## Operation

- Per-lane state is EMPTY or FULL, reflected directly on out_valid[k].
- A lane's dout is forced to 0 while the lane is EMPTY. This keeps the legacy rule that deselected outputs read 0.
- Lane k can take a word this cycle (can_wr[k]) when it is EMPTY, or when it is FULL and out_ready[k]=1 (drain and refill in the same cycle).
- in_ready is decided as follows:
  - bcast=1: in_ready = AND of can_wr over all lanes.
  - bcast=0 and sel < NUM_OUT: in_ready = can_wr[sel].
  - bcast=0 and sel >= NUM_OUT: in_ready = 1.
- A word is accepted on the edge where in_valid and in_ready are both 1.
- Accepted with bcast=0 and sel in range: lane sel loads din and becomes FULL.
- Accepted with bcast=1: every lane loads din and becomes FULL.
- Accepted with bcast=0 and sel >= NUM_OUT:
  - the word is discarded and no lane changes;
  - err=1 for the next cycle;
  - drop_cnt increments unless it is already 255.
- Lane transitions on each edge:
  - EMPTY with a write: goes FULL.
  - FULL with out_ready and no write: goes EMPTY. dout reads 0 from the next cycle.
  - FULL with out_ready and a write: stays FULL with the new word.
  - FULL without out_ready: holds. No write can occur.
  - EMPTY without a write: holds, even if out_ready=1.
- Lanes are independent. A stall on lane j never blocks a unicast to lane k≠j. It does block a broadcast.
- The producer may change din/sel/bcast while in_valid=0. While in_valid=1 and in_ready=0, the producer holds them stable.

## Timing

- Latency: a word accepted at edge N drives out_valid/dout from just after edge N, i.e. it is visible in cycle N+1.
- Throughput per lane: one word per cycle while out_ready stays high.
- in_ready has a combinational path from out_ready, sel and bcast. There is no combinational path from din to any output.
- Reset (rst_n=0, any time, asynchronous):
  - out_valid=0, dout=0, err=0, drop_cnt=0 immediately;
  - any word in flight is lost;
  - in_ready follows its rule and therefore reads 1.
- First accept can occur at the first rising edge after rst_n deasserts.
- err is registered and high for exactly one cycle per dropped word. Back-to-back drops hold it high continuously.

## Test plan

- Reset mid-traffic: fill lanes 0 and 2, then pulse rst_n low between edges. Require out_valid=0000, dout=0 and drop_cnt=0 before the next edge, and in_ready=1.
- Unicast streaming: WIDTH=8, NUM_OUT=4, out_ready=1111. Send 0x11→lane0, 0x22→lane1, 0x33→lane2, 0x44→lane3 on consecutive cycles. Require each lane's out_valid high one cycle after its accept with the matching byte, and the other lanes reading 0.
- Lane stall isolation: out_ready[1]=0 with lane1 FULL (0xAA). Require in_ready=0 for sel=1, and lane1 holding 0xAA. Require a sel=3 word 0x55 accepted the same cycle. Raise out_ready[1] with a sel=1 word 0xBB pending: require drain and refill on the same edge, lane1 showing 0xBB with no EMPTY gap.
- Broadcast: with lane2 FULL and stalled, require bcast word 0x5A to see in_ready=0. Release out_ready[2]: require acceptance, then all four lanes valid with 0x5A.
- Out-of-range select: NUM_OUT=3, SEL_W=2, sel=3.
  - Send 0x77: require in_ready=1, a 1-cycle err pulse, no lane change and drop_cnt=1.
  - Send 300 such words: require drop_cnt to saturate at 255.
- Parameter sweep: repeat the unicast streaming scenario at WIDTH=16, NUM_OUT=8, SEL_W=3 with random valid/ready. Require a scoreboard match per lane with no loss, duplication or reordering.
